mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, default 2048: number of 64-bit words in the backing store; power of two, 16..65536.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states inserted before the response, range 0..15.
REQ-003 Parameter BASE_ADDR, default 0: word address mapped to backing-store index 0.
REQ-004 Port clock  input  1  single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  reset; synchronous and active-low.
REQ-006 Port addr  input  64  word address from the core.
REQ-007 Port wdata  input  64  write data from the core.
REQ-008 Port read  input  1  read request strobe, level-sensitive.
REQ-009 Port write  input  1  write request strobe, level-sensitive.
REQ-010 Port rdata  output  64  read data, valid only while ready=1 for a read.
REQ-011 Port ready  output  1  one-cycle completion pulse, used for both reads and writes.
REQ-012 Port err  output  1  one-cycle error pulse, coincident with ready.

Function
REQ-013 The block SHALL implement an FSM with three states: IDLE, WAIT and RESP.
REQ-014 In IDLE, read^write=1 SHALL capture addr, wdata and the operation type into registers.
- Next state is WAIT if WAIT_CYCLES>0, otherwise RESP.
REQ-015 In IDLE, read=write=1 SHALL be accepted as an illegal request.
- It completes as a no-op with err=1.
- It has the same latency as a legal request.
REQ-016 Strobes SHALL be ignored in WAIT and RESP; addr and wdata changes after capture SHALL have no effect.
REQ-017 WAIT SHALL last exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter, then move to RESP.
REQ-018 Latency: for a request sampled in IDLE at cycle T, ready SHALL be 1 exactly at cycle T+1+WAIT_CYCLES.
- RESP lasts one cycle, then returns to IDLE.
- A strobe still high in IDLE the cycle after RESP starts a new transaction.
REQ-019 In-range address: BASE_ADDR <= addr < BASE_ADDR+DEPTH, using full 64-bit unsigned compare.
- Index = (addr-BASE_ADDR)[log2(DEPTH)-1:0].
REQ-020 In-range write: the word SHALL be committed in the RESP cycle, rdata=0, err=0.
REQ-021 In-range read: rdata SHALL equal the stored word during the RESP cycle, err=0.
REQ-022 Out-of-range read: rdata=0 and err=1.
REQ-023 Out-of-range write: memory unchanged and err=1.
REQ-024 rdata SHALL be 0 whenever ready=0; ready and err SHALL never be high outside RESP.
REQ-025 Read-after-write to the same address SHALL return the newly written data.
- The earliest such read starts in the IDLE cycle immediately after the write's RESP.
REQ-026 Address wrap SHALL NOT occur: BASE_ADDR+DEPTH-1 is in range; BASE_ADDR+DEPTH and BASE_ADDR-1 are out of range.

Reset
REQ-027 While reset=0 at a clock edge, the block SHALL:
- go to IDLE;
- clear the counter and captured registers;
- drive ready=0, err=0, rdata=0 on the next cycle.
REQ-028 Reset mid-transaction (WAIT or RESP) SHALL abort the transaction.
- A pending write is not committed.
- No ready pulse is issued.
REQ-029 Memory contents SHALL NOT be cleared by reset; contents are undefined after power-up.
REQ-030 Strobes present in the first cycle after reset deasserts SHALL be accepted normally.

Structure
REQ-031 A shared package SHALL hold:
- FSM state enum (IDLE, WAIT, RESP);
- data/address width constant 64;
- the 4-bit wait-counter width.
REQ-032 The backing store SHALL be a separate sub-module, mem_array:
- single-port synchronous RAM, DEPTH x 64;
- write-enable and address inputs;
- combinational or registered read aligned so that data is valid in RESP.
REQ-033 Address decode, FSM and output registers SHALL live in mem_responder.

Verification
REQ-034 Write 0xDEADBEEF_CAFEF00D at addr 5, then read addr 5, WAIT_CYCLES=2.
- ready at T+3 for each transaction.
- Read rdata=0xDEADBEEF_CAFEF00D, err=0.
REQ-035 WAIT_CYCLES=0: read addr 0 after writing 0x1.
- ready at T+1, rdata=0x1.
REQ-036 Out-of-range accesses, DEPTH=2048, BASE_ADDR=0:
- read addr 2048 -> err=1, rdata=0;
- write 0xFF at addr 2048 -> err=1;
- read addr 2047 -> prior contents unchanged.
REQ-037 Illegal request: read=write=1 at addr 3 -> err=1 and ready at T+3; addr 3 contents unchanged.
REQ-038 Reset mid-write: write 0xAA at addr 7 and assert reset during WAIT.
- No ready pulse.
- Outputs are 0 on the next cycle.
- Subsequent read of addr 7 returns the old value.
REQ-039 Back-to-back: read strobe held high for 8 cycles, WAIT_CYCLES=2.
- Exactly two ready pulses, at T+3 and T+7.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types and widths for the mem_responder slice.
// No logic here; latency and backpressure live in the modules that import it.
package mem_responder_pkg;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_WAIT = 2'(WAIT);
  localparam logic [1:0] ST_RESP = 2'(RESP);

endpackage

// File: rtl/mem_array.sv
// Single-port DEPTH x 64 store: synchronous write, combinational read (zero-cycle read latency).
// No flow control; the owner keeps addr stable so data is valid in the response cycle.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = 2048,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory responder: one request at a time, ready/err pulse exactly 1+WAIT_CYCLES cycles after capture.
// Strobes are ignored while busy; a strobe held high is re-accepted in the IDLE cycle after RESP.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int                DEPTH       = 2048,
  parameter int                WAIT_CYCLES = 2,
  parameter logic [DATA_W-1:0] BASE_ADDR   = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              read,
  input  logic              write,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err
);

  localparam int                AW      = $clog2(DEPTH);
  localparam logic [DATA_W-1:0] DEPTH_W = DATA_W'(DEPTH);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [AW-1:0]     cap_idx;
  logic [DATA_W-1:0] cap_wdata;
  logic              cap_rd;
  logic              cap_wr;
  logic              cap_err;

  logic [DATA_W:0]   diff;
  logic              in_range;
  logic              mem_we;
  logic [DATA_W-1:0] mem_q;

  // The extra borrow bit rejects addresses below BASE_ADDR without any wrap-around.
  assign diff     = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign in_range = !diff[DATA_W] && (diff[DATA_W-1:0] < DEPTH_W);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cap_idx   <= '0;
      cap_wdata <= '0;
      cap_rd    <= 1'b0;
      cap_wr    <= 1'b0;
      cap_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (read || write) begin
            cap_idx   <= diff[AW-1:0];
            cap_wdata <= wdata;
            cap_rd    <= read && !write;
            cap_wr    <= write && !read;
            cap_err   <= (read && write) || !in_range;
            cnt       <= CNT_W'(WAIT_CYCLES);
            state     <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Gating with reset keeps a reset landing in RESP from pulsing ready or committing the write.
  assign ready  = (state == ST_RESP) && reset;
  assign err    = ready && cap_err;
  assign mem_we = ready && cap_wr && !cap_err;
  assign rdata  = (ready && cap_rd && !cap_err) ? mem_q : '0;

  mem_array #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clock (clock),
    .we    (mem_we),
    .addr  (cap_idx),
    .wdata (cap_wdata),
    .rdata (mem_q)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboarded bench for mem_responder: WAIT_CYCLES=2 and WAIT_CYCLES=0 instances side by side.
module tb_mem_responder;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [63:0] addr2, wdata2, rdata2, addr0, wdata0, rdata0;
  logic        read2, write2, ready2, err2;
  logic        read0, write0, ready0, err0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    logic        err;
    logic [63:0] rdata;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [63:0] a;
    logic [63:0] d;
    logic        e_err;
    logic [63:0] e_rdata;
  } vec_t;

  exp_t q2[$];
  exp_t q0[$];
  vec_t vecs[14];

  mem_responder #(.DEPTH(2048), .WAIT_CYCLES(2), .BASE_ADDR(64'd0)) dut2 (
    .clock(clock), .reset(reset), .addr(addr2), .wdata(wdata2), .read(read2),
    .write(write2), .rdata(rdata2), .ready(ready2), .err(err2)
  );

  mem_responder #(.DEPTH(2048), .WAIT_CYCLES(0), .BASE_ADDR(64'd0)) dut0 (
    .clock(clock), .reset(reset), .addr(addr0), .wdata(wdata0), .read(read0),
    .write(write0), .rdata(rdata0), .ready(ready0), .err(err0)
  );

  always @(posedge clock) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      if (ready2) begin
        if (q2.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL dut2_unexpected_ready actual=1 required=0 (cyc %0d)", cyc);
        end else begin
          exp_t e;
          e = q2.pop_front();
          chk("dut2_latency", 64'(cyc), 64'(e.cyc));
          chk("dut2_err", 64'(err2), 64'(e.err));
          chk("dut2_rdata", rdata2, e.rdata);
        end
      end else begin
        chk("dut2_idle_err", 64'(err2), 64'd0);
        chk("dut2_idle_rdata", rdata2, 64'd0);
      end
    end
  end

  always @(negedge clock) begin
    if (mon_en) begin
      if (ready0) begin
        if (q0.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL dut0_unexpected_ready actual=1 required=0 (cyc %0d)", cyc);
        end else begin
          exp_t e;
          e = q0.pop_front();
          chk("dut0_latency", 64'(cyc), 64'(e.cyc));
          chk("dut0_err", 64'(err0), 64'(e.err));
          chk("dut0_rdata", rdata0, e.rdata);
        end
      end else begin
        chk("dut0_idle_err", 64'(err0), 64'd0);
        chk("dut0_idle_rdata", rdata0, 64'd0);
      end
    end
  end

  // One-cycle strobe; addr/wdata are scrambled afterwards to show capture is final.
  task automatic issue(input int sel, input logic rd, input logic wr, input logic [63:0] a,
                       input logic [63:0] d, input logic e_err, input logic [63:0] e_rdata);
    exp_t e;
    @(negedge clock);
    e.err   = e_err;
    e.rdata = e_rdata;
    if (sel == 0) begin
      read0 = rd; write0 = wr; addr0 = a; wdata0 = d;
      e.cyc = cyc + 1;
      q0.push_back(e);
    end else begin
      read2 = rd; write2 = wr; addr2 = a; wdata2 = d;
      e.cyc = cyc + 3;
      q2.push_back(e);
    end
    @(negedge clock);
    if (sel == 0) begin
      read0 = 1'b0; write0 = 1'b0; addr0 = {$urandom, $urandom}; wdata0 = {$urandom, $urandom};
    end else begin
      read2 = 1'b0; write2 = 1'b0; addr2 = {$urandom, $urandom}; wdata2 = {$urandom, $urandom};
    end
  endtask

  task automatic drain(input int sel);
    for (int i = 0; i < 20; i++) begin
      if ((sel == 0 ? q0.size() : q2.size()) == 0) break;
      @(negedge clock);
    end
    if ((sel == 0 ? q0.size() : q2.size()) != 0) begin
      checks++;
      failures++;
      $display("FAIL dut%0d_timeout pending=%0d required=0", sel, (sel == 0 ? q0.size() : q2.size()));
      if (sel == 0) q0.delete(); else q2.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;

    vecs[0]  = '{1'b0, 1'b1, 64'd5,    64'hDEADBEEF_CAFEF00D, 1'b0, 64'd0};
    vecs[1]  = '{1'b1, 1'b0, 64'd5,    64'h0,                 1'b0, 64'hDEADBEEF_CAFEF00D};
    vecs[2]  = '{1'b0, 1'b1, 64'd2047, 64'h12345678,          1'b0, 64'd0};
    vecs[3]  = '{1'b1, 1'b0, 64'd2048, 64'h0,                 1'b1, 64'd0};
    vecs[4]  = '{1'b0, 1'b1, 64'd2048, 64'hFF,                1'b1, 64'd0};
    vecs[5]  = '{1'b1, 1'b0, 64'd2047, 64'h0,                 1'b0, 64'h12345678};
    vecs[6]  = '{1'b0, 1'b1, 64'd3,    64'h3333,              1'b0, 64'd0};
    vecs[7]  = '{1'b1, 1'b1, 64'd3,    64'h9999,              1'b1, 64'd0};
    vecs[8]  = '{1'b1, 1'b0, 64'd3,    64'h0,                 1'b0, 64'h3333};
    vecs[9]  = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,  1'b1, 64'd0};
    vecs[10] = '{1'b0, 1'b1, 64'd0,    64'hABC,               1'b0, 64'd0};
    vecs[11] = '{1'b1, 1'b0, 64'd0,    64'h0,                 1'b0, 64'hABC};
    vecs[12] = '{1'b0, 1'b1, 64'd7,    64'h77,                1'b0, 64'd0};
    vecs[13] = '{1'b1, 1'b0, 64'd7,    64'h0,                 1'b0, 64'h77};

    reset = 1'b0;
    read2 = 1'b0; write2 = 1'b0; addr2 = '0; wdata2 = '0;
    read0 = 1'b0; write0 = 1'b0; addr0 = '0; wdata0 = '0;
    repeat (3) @(negedge clock);
    chk("reset_ready2", 64'(ready2), 64'd0);
    chk("reset_err2", 64'(err2), 64'd0);
    chk("reset_rdata2", rdata2, 64'd0);
    chk("reset_ready0", 64'(ready0), 64'd0);
    chk("reset_err0", 64'(err0), 64'd0);
    chk("reset_rdata0", rdata0, 64'd0);
    reset  = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 14; i++) begin
      issue(2, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].e_err, vecs[i].e_rdata);
      drain(2);
    end

    // WAIT_CYCLES=0: read issued in the IDLE cycle right after the write's RESP.
    issue(0, 1'b0, 1'b1, 64'd0, 64'h1, 1'b0, 64'd0);
    issue(0, 1'b1, 1'b0, 64'd0, 64'h0, 1'b0, 64'h1);
    issue(0, 1'b1, 1'b0, 64'd2048, 64'h0, 1'b1, 64'd0);
    drain(0);

    // Reset during WAIT of a write: no ready, store keeps 0x77, first post-reset strobe accepted.
    @(negedge clock);
    write2 = 1'b1; addr2 = 64'd7; wdata2 = 64'hAA;
    @(negedge clock);
    write2 = 1'b0;
    reset  = 1'b0;
    @(negedge clock);
    chk("rst_mid_ready", 64'(ready2), 64'd0);
    chk("rst_mid_err", 64'(err2), 64'd0);
    chk("rst_mid_rdata", rdata2, 64'd0);
    reset = 1'b1;
    read2 = 1'b1; addr2 = 64'd7;
    e.err = 1'b0; e.rdata = 64'h77; e.cyc = cyc + 3;
    q2.push_back(e);
    @(negedge clock);
    read2 = 1'b0;
    drain(2);

    // Read strobe held for 8 cycles: two responses, 4 cycles apart.
    issue(2, 1'b0, 1'b1, 64'd9, 64'h99, 1'b0, 64'd0);
    drain(2);
    @(negedge clock);
    read2 = 1'b1; addr2 = 64'd9;
    e.err = 1'b0; e.rdata = 64'h99;
    e.cyc = cyc + 3; q2.push_back(e);
    e.cyc = cyc + 7; q2.push_back(e);
    repeat (8) @(negedge clock);
    read2 = 1'b0;
    drain(2);
    repeat (6) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
